// File: rtl/wordline_ctrl16.sv
// Wordline sequencer for a 16-way one-hot row decoder: runs setup/precharge/fire per beat,
// gates the decoder output onto registered wordlines and flags any decode that is not 1<<dec_a.
module wordline_ctrl16 #(
  parameter int unsigned PRECH_CYC = 1,
  parameter int unsigned WL_CYC    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_addr,
  input  logic [3:0]  req_len,
  output logic [3:0]  dec_a,
  input  logic [15:0] dec_y,
  output logic        precharge,
  output logic [15:0] wl,
  output logic        beat_done,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE, the requester holds valid and payload until then,
  // and valid seen in any other state is ignored (nothing is queued).

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PRECH = 3'd2,
    S_FIRE  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] PRECH_LAST = 4'(PRECH_CYC - 1);
  localparam logic [3:0] WL_LAST    = 4'(WL_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  beats_left_q;
  logic        beat_bad_q;
  logic [15:0] wl_q;
  logic        err_q;

  logic        accept;
  logic        mismatch;
  logic        prech_last;
  logic        fire_last;
  logic        last_beat;
  logic        wl_load;

  assign accept     = req_valid && (state_q == S_IDLE);
  assign mismatch   = (dec_y !== (16'h0001 << dec_a));
  assign prech_last = (cnt_q == PRECH_LAST);
  assign fire_last  = (cnt_q == WL_LAST);
  assign last_beat  = (beats_left_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_PRECH;
        cnt_d   = 4'd0;
      end
      S_PRECH: begin
        if (prech_last) begin
          state_d = S_FIRE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FIRE: begin
        if (fire_last) begin
          state_d = last_beat ? S_DONE : S_SETUP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // wl for the next cycle is captured from dec_y only when that cycle is FIRE and the
  // decode is clean; once a beat has seen a bad decode it stays dark until the next SETUP.
  assign wl_load = (state_d == S_FIRE) && !mismatch && !beat_bad_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      beats_left_q <= 4'd0;
      beat_bad_q   <= 1'b0;
      wl_q         <= 16'h0000;
      err_q        <= 1'b0;
      dec_a        <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wl_q    <= wl_load ? dec_y : 16'h0000;

      if (state_q == S_SETUP) begin
        beat_bad_q <= 1'b0;
      end else if ((state_q == S_FIRE || state_d == S_FIRE) && mismatch) begin
        beat_bad_q <= 1'b1;
      end

      if (accept) begin
        dec_a        <= req_addr;
        beats_left_q <= req_len;
        err_q        <= 1'b0;
      end else begin
        if (state_q == S_FIRE && mismatch) err_q <= 1'b1;
        if (state_q == S_FIRE && fire_last && !last_beat) begin
          beats_left_q <= beats_left_q - 4'd1;
          dec_a        <= dec_a + 4'd1;
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign precharge = (state_q == S_PRECH);
  assign beat_done = (state_q == S_FIRE) && fire_last;
  assign done      = (state_q == S_DONE);
  assign wl        = wl_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wordline_ctrl16.sv
// Bench for wordline_ctrl16: default-timing and (2,3)-timing instances driven from a vector
// table, hand sequences and random bursts, each compared cycle by cycle with a burst trace model.
module tb_wordline_ctrl16;

  logic        clk;
  logic        reset_n;

  logic        req_valid0, req_valid1;
  logic [3:0]  req_addr0, req_addr1;
  logic [3:0]  req_len0, req_len1;
  logic        req_ready0, req_ready1;
  logic [3:0]  dec_a0, dec_a1;
  logic [15:0] dec_y0, dec_y1;
  logic        precharge0, precharge1;
  logic [15:0] wl0, wl1;
  logic        beat_done0, beat_done1;
  logic        done0, done1;
  logic        err0, err1;
  logic [2:0]  dbg_state0, dbg_state1;

  logic        fault0, fault1;
  logic        sel_r;

  logic        s_ready, s_prech, s_bdone, s_done, s_err;
  logic [15:0] s_wl;
  logic [3:0]  s_dec_a;

  int n_cmp;
  int n_err;

  typedef struct {
    bit         sel;
    logic [3:0] addr;
    logic [3:0] len;
    logic [15:0] fmask;
    int         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs[4];

  wordline_ctrl16 u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_addr(req_addr0), .req_len(req_len0),
    .dec_a(dec_a0), .dec_y(dec_y0),
    .precharge(precharge0), .wl(wl0),
    .beat_done(beat_done0), .done(done0), .err(err0),
    .dbg_state(dbg_state0)
  );

  wordline_ctrl16 #(.PRECH_CYC(2), .WL_CYC(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_addr(req_addr1), .req_len(req_len1),
    .dec_a(dec_a1), .dec_y(dec_y1),
    .precharge(precharge1), .wl(wl1),
    .beat_done(beat_done1), .done(done1), .err(err1),
    .dbg_state(dbg_state1)
  );

  // External decoder model, with a fault override that produces a two-hot output.
  always_comb begin
    dec_y0 = fault0 ? 16'h0003 : (16'h0001 << dec_a0);
    dec_y1 = fault1 ? 16'h0003 : (16'h0001 << dec_a1);
  end

  always_comb begin
    s_ready = sel_r ? req_ready1 : req_ready0;
    s_prech = sel_r ? precharge1 : precharge0;
    s_bdone = sel_r ? beat_done1 : beat_done0;
    s_done  = sel_r ? done1      : done0;
    s_err   = sel_r ? err1       : err0;
    s_wl    = sel_r ? wl1        : wl0;
    s_dec_a = sel_r ? dec_a1     : dec_a0;
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit sel, input bit v, input logic [3:0] a, input logic [3:0] l);
    if (sel) begin
      req_valid1 = v; req_addr1 = a; req_len1 = l;
    end else begin
      req_valid0 = v; req_addr0 = a; req_len0 = l;
    end
  endtask

  task automatic set_fault(input bit sel, input bit f);
    if (sel) fault1 = f;
    else     fault0 = f;
  endtask

  // Runs one burst from a negedge, checking every cycle from accept to the idle cycle after done.
  task automatic run_burst(input bit sel, input logic [3:0] addr, input logic [3:0] len,
                           input logic [15:0] fmask, input bit hold,
                           input logic [3:0] naddr, input logic [3:0] nlen,
                           input int exp_done);
    int p, w, b, n, t, done_k, wl_bits, exp_bits;
    sel_r = sel;
    p = sel ? 2 : 1;
    w = sel ? 3 : 2;
    b = 1 + p + w;
    n = (int'(len) + 1) * b;
    drive_req(sel, 1'b1, addr, len);
    #1;
    check("ready_at_req", {31'd0, s_ready}, 32'd1);
    t = 0;
    while (!s_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("ready_wait_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (hold) drive_req(sel, 1'b1, naddr, nlen);
    else      drive_req(sel, 1'b0, 4'd0, 4'd0);
    done_k   = -1;
    wl_bits  = 0;
    exp_bits = 0;
    for (int k = 0; k <= n + 1; k++) begin
      int bt, ph;
      logic [3:0]  row;
      logic [15:0] e_wl;
      logic        e_err, fire;
      if (k > 0) @(negedge clk);
      bt   = (k < n) ? k / b : int'(len);
      ph   = k % b;
      row  = addr + 4'(bt);
      set_fault(sel, (k < n) && fmask[bt]);
      fire = (k < n) && (ph > p);
      e_wl = (fire && !fmask[bt]) ? (16'h0001 << row) : 16'h0000;
      e_err = 1'b0;
      for (int j = 0; j <= int'(len); j++)
        if (fmask[j] && (j * b + 1 + p) < k) e_err = 1'b1;
      if (fire && !fmask[bt]) exp_bits++;
      wl_bits += $countones(s_wl);
      if (s_done && done_k < 0) done_k = k;
      check($sformatf("wl a%0d k%0d", addr, k), {16'd0, s_wl}, {16'd0, e_wl});
      check($sformatf("precharge a%0d k%0d", addr, k), {31'd0, s_prech},
            {31'd0, (k < n) && ph >= 1 && ph <= p});
      check($sformatf("beat_done a%0d k%0d", addr, k), {31'd0, s_bdone},
            {31'd0, (k < n) && ph == b - 1});
      check($sformatf("done a%0d k%0d", addr, k), {31'd0, s_done}, {31'd0, k == n});
      check($sformatf("req_ready a%0d k%0d", addr, k), {31'd0, s_ready}, {31'd0, k == n + 1});
      check($sformatf("err a%0d k%0d", addr, k), {31'd0, s_err}, {31'd0, e_err});
      check($sformatf("dec_a a%0d k%0d", addr, k), {28'd0, s_dec_a}, {28'd0, row});
    end
    check($sformatf("done_cycle a%0d", addr), done_k, exp_done);
    check($sformatf("wl_bit_cycles a%0d", addr), wl_bits, exp_bits);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sel_r = 1'b0;
    fault0 = 1'b0;
    fault1 = 1'b0;
    reset_n = 1'b0;
    drive_req(1'b0, 1'b0, 4'd0, 4'd0);
    drive_req(1'b1, 1'b0, 4'd0, 4'd0);

    vecs[0] = '{sel: 1'b0, addr: 4'd5,  len: 4'd0,  fmask: 16'h0000, exp_done: 4,  exp_err: 1'b0};
    vecs[1] = '{sel: 1'b0, addr: 4'd0,  len: 4'd0,  fmask: 16'h0001, exp_done: 4,  exp_err: 1'b1};
    vecs[2] = '{sel: 1'b0, addr: 4'd14, len: 4'd3,  fmask: 16'h0000, exp_done: 16, exp_err: 1'b0};
    vecs[3] = '{sel: 1'b1, addr: 4'd0,  len: 4'd15, fmask: 16'h0000, exp_done: 96, exp_err: 1'b0};

    // reset values, before any clock edge
    #3;
    check("rst ready0", {31'd0, req_ready0}, 32'd1);
    check("rst wl0", {16'd0, wl0}, 32'd0);
    check("rst prech0", {31'd0, precharge0}, 32'd0);
    check("rst done0", {31'd0, done0}, 32'd0);
    check("rst err0", {31'd0, err0}, 32'd0);
    check("rst dec_a0", {28'd0, dec_a0}, 32'd0);
    check("rst ready1", {31'd0, req_ready1}, 32'd1);
    check("rst dbg_state0", {29'd0, dbg_state0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_burst(vecs[i].sel, vecs[i].addr, vecs[i].len, vecs[i].fmask, 1'b0, 4'd0, 4'd0,
                vecs[i].exp_done);
      check($sformatf("vec%0d final err", i), {31'd0, s_err}, {31'd0, vecs[i].exp_err});
      @(negedge clk);
    end

    // valid held across a whole burst: the next request goes in only after done
    run_burst(1'b0, 4'd3, 4'd1, 16'h0000, 1'b1, 4'd7, 4'd0, 8);
    run_burst(1'b0, 4'd7, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4);
    @(negedge clk);

    // reset during FIRE drops wl/precharge without a clock edge; the burst is lost
    sel_r = 1'b0;
    drive_req(1'b0, 1'b1, 4'd9, 4'd2);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    check("t5 precharge", {31'd0, precharge0}, 32'd1);
    @(negedge clk);
    check("t5 wl before reset", {16'd0, wl0}, 32'h0200);
    #1 reset_n = 1'b0;
    #1;
    check("t5 wl async", {16'd0, wl0}, 32'd0);
    check("t5 prech async", {31'd0, precharge0}, 32'd0);
    check("t5 ready async", {31'd0, req_ready0}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("t5 no done c%0d", c), {31'd0, done0}, 32'd0);
      check($sformatf("t5 ready c%0d", c), {31'd0, req_ready0}, 32'd1);
      check($sformatf("t5 wl c%0d", c), {16'd0, wl0}, 32'd0);
    end

    // random bursts on both timings, with occasional faulty beats
    for (int r = 0; r < 16; r++) begin
      bit          rs;
      logic [3:0]  ra, rl;
      logic [15:0] rf;
      rs = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 5));
      rf = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
      run_burst(rs, ra, rl, rf, 1'b0, 4'd0, 4'd0, (int'(rl) + 1) * (rs ? 6 : 4));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
